// File: rtl/mem_arbiter_pkg.sv
// Shared types, lane constants and the alignment rule for the data-memory arbiter.
package mem_arbiter_pkg;

  localparam int BYTE_W = 8;
  localparam int HALF_W = 16;
  localparam int WORD_W = 32;

  // Access size as encoded on the load/store port.
  typedef enum logic [1:0] {
    BYTE    = 2'b00,
    HALF    = 2'b01,
    WORD    = 2'b10,
    ILLEGAL = 2'b11
  } ls_size_e;

  // IDLE accepts requests; RMW_WR commits the merged word of a sub-word store.
  typedef enum logic {
    IDLE   = 1'b0,
    RMW_WR = 1'b1
  } arb_state_e;

  // True when the access cannot be performed: unaligned half/word or illegal size.
  function automatic logic misaligned(input ls_size_e size, input logic [1:0] lane);
    logic bad;
    bad = 1'b1;
    case (size)
      BYTE:    bad = 1'b0;
      HALF:    bad = lane[0];
      WORD:    bad = |lane;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane datapath: load extraction with sign/zero extension, and the
// read-modify-write merge that inserts store data into the old word.
module lsu_align
  import mem_arbiter_pkg::*;
(
  input  logic [WORD_W-1:0] rdata_i,
  input  logic [WORD_W-1:0] wdata_i,
  input  ls_size_e          size_i,
  input  logic [1:0]        lane_i,
  input  logic              unsigned_i,
  output logic [WORD_W-1:0] load_data_o,
  output logic [WORD_W-1:0] merged_o
);

  logic [BYTE_W-1:0] byte_sel;
  logic [HALF_W-1:0] half_sel;
  logic              byte_sx;
  logic              half_sx;

  // Extract the addressed byte/half from the read word and extend it.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
    load_data_o = rdata_i;
    byte_sel    = rdata_i[{lane_i, 3'b000} +: BYTE_W];
    half_sel    = lane_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    byte_sx     = ~unsigned_i & byte_sel[BYTE_W-1];
    half_sx     = ~unsigned_i & half_sel[HALF_W-1];
    case (size_i)
      BYTE:    load_data_o = {{(WORD_W-BYTE_W){byte_sx}}, byte_sel};
      HALF:    load_data_o = {{(WORD_W-HALF_W){half_sx}}, half_sel};
      default: load_data_o = rdata_i;
    endcase
  end

  // Overlay the right-aligned store data onto its lane of the old word.
  always_comb begin
    merged_o = rdata_i;
    case (size_i)
      BYTE:    merged_o[{lane_i, 3'b000} +: BYTE_W]     = wdata_i[BYTE_W-1:0];
      HALF:    merged_o[{lane_i[1], 4'b0000} +: HALF_W] = wdata_i[HALF_W-1:0];
      WORD:    merged_o = wdata_i;
      default: merged_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port data-memory arbiter between instruction fetch and load/store.
// Round-robin on contention, registered responses, two-cycle RMW for
// sub-word stores, misaligned/illegal accesses answered with ls_err.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  // fetch port
  input  logic              if_req_valid,
  output logic              if_req_ready,
  input  logic [ADDR_W+1:0] if_addr,
  output logic              if_resp_valid,
  output logic [31:0]       if_resp_data,
  // load/store port
  input  logic              ls_req_valid,
  output logic              ls_req_ready,
  input  logic [ADDR_W+1:0] ls_addr,
  input  logic              ls_we,
  input  logic [1:0]        ls_size,
  input  logic              ls_unsigned,
  input  logic [31:0]       ls_wdata,
  output logic              ls_resp_valid,
  output logic [31:0]       ls_resp_data,
  output logic              ls_err,
  // memory port
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_data_in,
  output logic              mem_str,
  input  logic [31:0]       mem_data_out
);

  arb_state_e        state_q, state_d;
  logic              last_ls_q, last_ls_d;   // 1: last accepted request came from LS
  logic [ADDR_W-1:0] addr_q, addr_d;         // word address held across RMW
  logic [WORD_W-1:0] merge_q, merge_d;       // merged word committed in RMW_WR

  logic              if_resp_valid_q, if_resp_valid_d;
  logic [31:0]       if_resp_data_q, if_resp_data_d;
  logic              ls_resp_valid_q, ls_resp_valid_d;
  logic [31:0]       ls_resp_data_q, ls_resp_data_d;
  logic              ls_err_q, ls_err_d;

  logic              grant_if;
  logic              grant_ls;
  ls_size_e          size;
  logic              ls_bad;
  logic [WORD_W-1:0] load_data;
  logic [WORD_W-1:0] merged;
  logic              unused_if_lane;

  // Fetches are always whole words; the byte offset carries no information.
  assign unused_if_lane = ^if_addr[1:0];

  assign size   = ls_size_e'(ls_size);
  assign ls_bad = misaligned(size, ls_addr[1:0]);

  lsu_align u_align (
    .rdata_i     (mem_data_out),
    .wdata_i     (ls_wdata),
    .size_i      (size),
    .lane_i      (ls_addr[1:0]),
    .unsigned_i  (ls_unsigned),
    .load_data_o (load_data),
    .merged_o    (merged)
  );

  // Round-robin winner selection; only IDLE grants anything.
  always_comb begin
    grant_if = 1'b0;
    grant_ls = 1'b0;
    if (state_q == IDLE) begin
      if (ls_req_valid && (!if_req_valid || !last_ls_q)) begin
        grant_ls = 1'b1;
      end else if (if_req_valid) begin
        grant_if = 1'b1;
      end
    end
  end

  assign if_req_ready = grant_if;
  assign ls_req_ready = grant_ls;

  // Next-state, memory control and response staging for the accepted request.
  always_comb begin
    state_d         = state_q;
    last_ls_d       = last_ls_q;
    addr_d          = addr_q;
    merge_d         = merge_q;
    mem_addr        = addr_q;
    mem_data_in     = merge_q;
    mem_str         = 1'b0;
    if_resp_valid_d = 1'b0;
    if_resp_data_d  = if_resp_data_q;
    ls_resp_valid_d = 1'b0;
    ls_resp_data_d  = ls_resp_data_q;
    ls_err_d        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (grant_if) begin
          last_ls_d       = 1'b0;
          mem_addr        = if_addr[ADDR_W+1:2];
          if_resp_valid_d = 1'b1;
          if_resp_data_d  = mem_data_out;
        end else if (grant_ls) begin
          last_ls_d = 1'b1;
          mem_addr  = ls_addr[ADDR_W+1:2];
          if (ls_bad) begin
            // Rejected without touching memory.
            ls_resp_valid_d = 1'b1;
            ls_resp_data_d  = '0;
            ls_err_d        = 1'b1;
          end else if (!ls_we) begin
            ls_resp_valid_d = 1'b1;
            ls_resp_data_d  = load_data;
          end else if (size == WORD) begin
            mem_str         = 1'b1;
            mem_data_in     = ls_wdata;
            ls_resp_valid_d = 1'b1;
            ls_resp_data_d  = '0;
          end else begin
            // Sub-word store: capture old word with the new lane, commit next cycle.
            addr_d  = ls_addr[ADDR_W+1:2];
            merge_d = merged;
            state_d = RMW_WR;
          end
        end
      end
      RMW_WR: begin
        mem_addr        = addr_q;
        mem_data_in     = merge_q;
        mem_str         = 1'b1;
        ls_resp_valid_d = 1'b1;
        ls_resp_data_d  = '0;
        state_d         = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, arbitration pointer, RMW holding registers and registered responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      last_ls_q       <= 1'b0;
      addr_q          <= '0;
      // NOTE: the merge register is reset like control state so a dropped RMW leaves no stale word behind.
      merge_q         <= '0;
      if_resp_valid_q <= 1'b0;
      if_resp_data_q  <= '0;
      ls_resp_valid_q <= 1'b0;
      ls_resp_data_q  <= '0;
      ls_err_q        <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q         <= state_d;
      last_ls_q       <= last_ls_d;
      addr_q          <= addr_d;
      merge_q         <= merge_d;
      if_resp_valid_q <= if_resp_valid_d;
      if_resp_data_q  <= if_resp_data_d;
      ls_resp_valid_q <= ls_resp_valid_d;
      ls_resp_data_q  <= ls_resp_data_d;
      ls_err_q        <= ls_err_d;
    end
  end

  assign if_resp_valid = if_resp_valid_q;
  assign if_resp_data  = if_resp_data_q;
  assign ls_resp_valid = ls_resp_valid_q;
  assign ls_resp_data  = ls_resp_data_q;
  assign ls_err        = ls_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized
// traffic against a word-array reference model of the memory system.
module tb_mem_arbiter;

  localparam int ADDR_W = 12;
  localparam int NWORDS = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              if_req_valid = 1'b0;
  logic              if_req_ready;
  logic [ADDR_W+1:0] if_addr = '0;
  logic              if_resp_valid;
  logic [31:0]       if_resp_data;
  logic              ls_req_valid = 1'b0;
  logic              ls_req_ready;
  logic [ADDR_W+1:0] ls_addr = '0;
  logic              ls_we = 1'b0;
  logic [1:0]        ls_size = 2'b10;
  logic              ls_unsigned = 1'b0;
  logic [31:0]       ls_wdata = '0;
  logic              ls_resp_valid;
  logic [31:0]       ls_resp_data;
  logic              ls_err;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_data_in;
  logic              mem_str;
  logic [31:0]       mem_data_out;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(ADDR_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .if_req_valid  (if_req_valid),
    .if_req_ready  (if_req_ready),
    .if_addr       (if_addr),
    .if_resp_valid (if_resp_valid),
    .if_resp_data  (if_resp_data),
    .ls_req_valid  (ls_req_valid),
    .ls_req_ready  (ls_req_ready),
    .ls_addr       (ls_addr),
    .ls_we         (ls_we),
    .ls_size       (ls_size),
    .ls_unsigned   (ls_unsigned),
    .ls_wdata      (ls_wdata),
    .ls_resp_valid (ls_resp_valid),
    .ls_resp_data  (ls_resp_data),
    .ls_err        (ls_err),
    .mem_addr      (mem_addr),
    .mem_data_in   (mem_data_in),
    .mem_str       (mem_str),
    .mem_data_out  (mem_data_out)
  );

  // Memory outside the block: combinational read, synchronous write, bench preload port.
  logic [31:0]       tb_mem [0:(1<<ADDR_W)-1];
  logic              pl_en = 1'b0;
  logic [ADDR_W-1:0] pl_addr = '0;
  logic [31:0]       pl_data = '0;
  assign mem_data_out = tb_mem[mem_addr];
  always @(posedge clk) begin
    if (mem_str) tb_mem[mem_addr] <= mem_data_in;
    else if (pl_en) tb_mem[pl_addr] <= pl_data;
  end

  // Counters
  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int str_cnt  = 0;

  // Reference model state
  logic [31:0] ref_mem [0:NWORDS-1];
  bit          m_last_ls = 1'b0;
  bit          m_busy = 1'b0;
  int          m_rmw_word = 0;
  logic [31:0] m_rmw_data = '0;
  int          exp_if_due = -1;
  logic [31:0] exp_if_data = '0;
  int          exp_ls_due = -1;
  logic [31:0] exp_ls_data = '0;
  bit          exp_ls_err = 1'b0;

  // Requester state
  bit          if_pend = 1'b0;
  logic [13:0] if_a = '0;
  bit          ls_pend = 1'b0;
  logic [13:0] ls_a = '0;
  bit          ls_w = 1'b0;
  logic [1:0]  ls_sz = 2'b10;
  bit          ls_u = 1'b0;
  logic [31:0] ls_d = '0;

  // Last load/store response seen on the bus
  logic [31:0] obs_ls_data = '0;
  logic        obs_ls_err = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic model_reset();
    m_busy     = 1'b0;
    m_last_ls  = 1'b0;
    exp_if_due = -1;
    exp_ls_due = -1;
    if_pend    = 1'b0;
    ls_pend    = 1'b0;
  endtask

  // One clock: drive requests, then check responses/readys/write strobe against the model.
  task automatic step();
    bit          g_if, g_ls, exp_str, bad;
    int          w, lane, nbits;
    logic [31:0] v, mask;
    @(posedge clk);
    cyc++;
    #1;
    if_req_valid = if_pend;
    if_addr      = if_a;
    ls_req_valid = ls_pend;
    ls_addr      = ls_a;
    ls_we        = ls_w;
    ls_size      = ls_sz;
    ls_unsigned  = ls_u;
    ls_wdata     = ls_d;
    @(negedge clk);

    check("if_resp_valid", 32'(if_resp_valid), 32'(exp_if_due == cyc));
    if (exp_if_due == cyc) check("if_resp_data", if_resp_data, exp_if_data);
    check("ls_resp_valid", 32'(ls_resp_valid), 32'(exp_ls_due == cyc));
    if (exp_ls_due == cyc) begin
      check("ls_resp_data", ls_resp_data, exp_ls_data);
      check("ls_err", 32'(ls_err), 32'(exp_ls_err));
    end
    if (ls_resp_valid) begin
      obs_ls_data = ls_resp_data;
      obs_ls_err  = ls_err;
    end

    g_ls = !m_busy && ls_pend && (!if_pend || !m_last_ls);
    g_if = !m_busy && if_pend && !g_ls;
    check("if_req_ready", 32'(if_req_ready), 32'(g_if));
    check("ls_req_ready", 32'(ls_req_ready), 32'(g_ls));

    exp_str = m_busy;
    if (m_busy) begin
      ref_mem[m_rmw_word] = m_rmw_data;
      m_busy = 1'b0;
    end

    if (g_if) begin
      m_last_ls   = 1'b0;
      exp_if_due  = cyc + 1;
      exp_if_data = ref_mem[int'(if_a[5:2])];
    end
    if (g_ls) begin
      m_last_ls = 1'b1;
      w     = int'(ls_a[5:2]);
      lane  = int'(ls_a[1:0]);
      nbits = 8 * (1 << ls_sz);
      bad   = (ls_sz == 2'b11) || ((int'(ls_a) % (1 << ls_sz)) != 0);
      mask  = (nbits == 32) ? 32'hFFFF_FFFF : ((32'd1 << nbits) - 32'd1);
      exp_ls_err  = 1'b0;
      exp_ls_data = '0;
      exp_ls_due  = cyc + 1;
      if (bad) begin
        exp_ls_err = 1'b1;
      end else if (!ls_w) begin
        v = (ref_mem[w] >> (8 * lane)) & mask;
        if (nbits < 32 && !ls_u && v[nbits-1]) v = v | ~mask;
        exp_ls_data = v;
      end else if (nbits == 32) begin
        ref_mem[w] = ls_d;
        exp_str    = 1'b1;
      end else begin
        m_rmw_word = w;
        m_rmw_data = (ref_mem[w] & ~(mask << (8 * lane))) | ((ls_d & mask) << (8 * lane));
        m_busy     = 1'b1;
        exp_ls_due = cyc + 2;
      end
    end
    check("mem_str", 32'(mem_str), 32'(exp_str));
    if (mem_str) str_cnt++;

    if (if_req_ready) if_pend = 1'b0;
    if (ls_req_ready) ls_pend = 1'b0;
  endtask

  task automatic preload(input int w, input logic [31:0] val);
    pl_en   = 1'b1;
    pl_addr = ADDR_W'(w);
    pl_data = val;
    ref_mem[w] = val;
    step();
    pl_en = 1'b0;
  endtask

  // Issue one load/store, wait (bounded) for acceptance, then let its response land.
  task automatic do_ls(input logic [13:0] a, input bit we, input logic [1:0] sz,
                       input bit u, input logic [31:0] d);
    ls_pend = 1'b1; ls_a = a; ls_w = we; ls_sz = sz; ls_u = u; ls_d = d;
    for (int n = 0; n < 8 && ls_pend; n++) step();
    check("ls_accepted", 32'(ls_pend), 32'd0);
    ls_pend = 1'b0;
    step();
    step();
  endtask

  task automatic drain();
    for (int n = 0; n < 8 && (if_pend || ls_pend); n++) step();
    check("drained", 32'({if_pend, ls_pend}), 32'd0);
    if_pend = 1'b0;
    ls_pend = 1'b0;
    step();
    step();
  endtask

  initial begin
    int          s0;
    logic [3:0]  seq_ls, seq_if;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_if_resp_valid", 32'(if_resp_valid), 32'd0);
    check("rst_ls_resp_valid", 32'(ls_resp_valid), 32'd0);
    check("rst_ls_err", 32'(ls_err), 32'd0);
    check("rst_if_resp_data", if_resp_data, 32'd0);
    check("rst_ls_resp_data", ls_resp_data, 32'd0);
    check("rst_mem_str", 32'(mem_str), 32'd0);
    rst_n = 1'b1;
    model_reset();

    for (int i = 0; i < NWORDS; i++) preload(i, $urandom());

    // Contention from reset: LS, IF, LS, IF
    seq_ls = '0;
    seq_if = '0;
    for (int k = 0; k < 4; k++) begin
      if (!if_pend) begin if_pend = 1'b1; if_a = 14'($urandom_range(0, 63)); end
      if (!ls_pend) begin
        ls_pend = 1'b1; ls_a = 14'($urandom_range(0, 15) * 4);
        ls_w = 1'b0; ls_sz = 2'b10; ls_u = 1'b0;
      end
      step();
      seq_ls = {seq_ls[2:0], ls_req_ready};
      seq_if = {seq_if[2:0], if_req_ready};
    end
    check("contention_ls_grants", 32'(seq_ls), 32'hA);
    check("contention_if_grants", 32'(seq_if), 32'h5);
    drain();

    // Word store then word load
    s0 = str_cnt;
    do_ls(14'h010, 1'b1, 2'b10, 1'b0, 32'hDEADBEEF);
    check("sw_str_pulses", 32'(str_cnt - s0), 32'd1);
    do_ls(14'h010, 1'b0, 2'b10, 1'b0, 32'h0);
    check("lw_after_sw", obs_ls_data, 32'hDEADBEEF);

    // Sub-byte RMW store
    preload(8, 32'h11223344);
    s0 = str_cnt;
    do_ls(14'h022, 1'b1, 2'b00, 1'b0, 32'h000000AA);
    check("sb_str_pulses", 32'(str_cnt - s0), 32'd1);
    check("sb_mem_word", tb_mem[8], 32'h11AA3344);

    // Load extension
    preload(8, 32'h80FF7F01);
    do_ls(14'h023, 1'b0, 2'b00, 1'b0, 32'h0);
    check("lb_0x023", obs_ls_data, 32'hFFFFFF80);
    do_ls(14'h023, 1'b0, 2'b00, 1'b1, 32'h0);
    check("lbu_0x023", obs_ls_data, 32'h00000080);
    do_ls(14'h020, 1'b0, 2'b01, 1'b0, 32'h0);
    check("lh_0x020", obs_ls_data, 32'h00007F01);

    // Misaligned and illegal
    s0 = str_cnt;
    do_ls(14'h021, 1'b0, 2'b10, 1'b0, 32'h0);
    check("lw_0x021_err", 32'(obs_ls_err), 32'd1);
    check("lw_0x021_data", obs_ls_data, 32'd0);
    do_ls(14'h023, 1'b1, 2'b01, 1'b0, 32'h1234);
    check("sh_0x023_err", 32'(obs_ls_err), 32'd1);
    do_ls(14'h020, 1'b0, 2'b11, 1'b0, 32'h0);
    check("size11_err", 32'(obs_ls_err), 32'd1);
    check("err_no_str", 32'(str_cnt - s0), 32'd0);

    // Reset during RMW_WR drops the write
    preload(8, 32'h11223344);
    ls_pend = 1'b1; ls_a = 14'h021; ls_w = 1'b1; ls_sz = 2'b00; ls_u = 1'b0; ls_d = 32'h55;
    for (int n = 0; n < 8 && ls_pend; n++) step();
    check("rmw_accepted", 32'(ls_pend), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    if_req_valid = 1'b0;
    ls_req_valid = 1'b0;
    #1;
    check("rst_rmw_mem_str", 32'(mem_str), 32'd0);
    check("rst_rmw_ls_resp", 32'(ls_resp_valid), 32'd0);
    @(negedge clk);
    check("rst_rmw_ls_resp_hold", 32'(ls_resp_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    check("rst_rmw_mem_word", tb_mem[8], 32'h11223344);
    if_pend = 1'b1;
    if_a    = 14'h020;
    step();
    check("fetch_after_reset", 32'(if_pend), 32'd0);
    step();

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      if (!if_pend && ($urandom_range(0, 1) == 1)) begin
        if_pend = 1'b1;
        if_a    = 14'($urandom_range(0, 63));
      end
      if (!ls_pend && ($urandom_range(0, 2) != 0)) begin
        ls_pend = 1'b1;
        ls_a    = 14'($urandom_range(0, 63));
        ls_w    = 1'($urandom_range(0, 1));
        ls_sz   = 2'($urandom_range(0, 3));
        ls_u    = 1'($urandom_range(0, 1));
        ls_d    = $urandom();
      end
      step();
    end
    drain();
    for (int i = 0; i < NWORDS; i++) check($sformatf("final_mem[%0d]", i), tb_mem[i], ref_mem[i]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
